// File: rtl/reg_file_wb.sv
// Write-back register file: 32x32, r0 hardwired to zero, with commit tracking.
// Define RF_WB_BYPASS_EN to forward same-cycle write-back data onto the read ports.
module reg_file_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_W,
  input  logic [4:0]  WriteReg_W,
  input  logic [31:0] Result_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WriteCount,
  output logic [4:0]  LastWriteReg,
  output logic [31:0] LastWriteData
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] count_q, count_d;
  logic [4:0]  last_reg_q, last_reg_d;
  logic [31:0] last_data_q, last_data_d;
  logic        commit;

  assign commit = RegWrite_W && (WriteReg_W != 5'd0);

  always_comb begin
    regs_d      = regs_q;
    count_d     = count_q;
    last_reg_d  = last_reg_q;
    last_data_d = last_data_q;
    if (commit) begin
      regs_d[WriteReg_W] = Result_W;
      count_d            = count_q + 32'd1;
      last_reg_d         = WriteReg_W;
      last_data_d        = Result_W;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      count_q     <= '0;
      last_reg_q  <= '0;
      last_data_q <= '0;
    end else begin
      regs_q      <= regs_d;
      count_q     <= count_d;
      last_reg_q  <= last_reg_d;
      last_data_q <= last_data_d;
    end
  end

`ifdef RF_WB_BYPASS_EN
  logic byp1, byp2;

  // Index 0 and reset are excluded so r0 and a clearing file never forward.
  assign byp1 = reset && commit && (WriteReg_W == A1);
  assign byp2 = reset && commit && (WriteReg_W == A2);
  assign RD1  = byp1 ? Result_W : regs_q[A1];
  assign RD2  = byp2 ? Result_W : regs_q[A2];
`else
  assign RD1 = regs_q[A1];
  assign RD2 = regs_q[A2];
`endif

  assign WriteCount    = count_q;
  assign LastWriteReg  = last_reg_q;
  assign LastWriteData = last_data_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: directed cases plus random traffic against an array model.
// Expectations for RD1/RD2 before the edge follow RF_WB_BYPASS_EN.
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic        RegWrite_W;
  logic [4:0]  WriteReg_W;
  logic [31:0] Result_W;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2, WriteCount, LastWriteData;
  logic [4:0]  LastWriteReg;

  int n_assert = 0;
  int n_fail   = 0;

  bit [31:0] mregs [32];
  bit [31:0] mcount;
  bit [4:0]  mlast_reg;
  bit [31:0] mlast_data;

  reg_file_wb dut (
    .clk(clk), .reset(reset),
    .RegWrite_W(RegWrite_W), .WriteReg_W(WriteReg_W), .Result_W(Result_W),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .WriteCount(WriteCount), .LastWriteReg(LastWriteReg),
    .LastWriteData(LastWriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcount     = '0;
    mlast_reg  = '0;
    mlast_data = '0;
  endtask

  function automatic bit [31:0] exp_rd(bit [4:0] a);
    bit fwd;
    if (!reset) return '0;
    fwd = RegWrite_W && (WriteReg_W == a) && (a != 0);
`ifdef RF_WB_BYPASS_EN
    if (fwd) return Result_W;
`endif
    return mregs[a];
  endfunction

  task automatic chk_state(string tag);
    chk({tag, "_cnt"}, WriteCount, mcount);
    chk({tag, "_lreg"}, {27'd0, LastWriteReg}, {27'd0, mlast_reg});
    chk({tag, "_ldat"}, LastWriteData, mlast_data);
  endtask

  // Drive one write-back cycle, check reads before and after the edge.
  task automatic cycle(string tag, bit we, bit [4:0] wr, bit [31:0] d,
                       bit [4:0] a1, bit [4:0] a2);
    RegWrite_W = we; WriteReg_W = wr; Result_W = d; A1 = a1; A2 = a2;
    #1;
    chk({tag, "_pre_rd1"}, RD1, exp_rd(a1));
    chk({tag, "_pre_rd2"}, RD2, exp_rd(a2));
    @(posedge clk);
    if (reset && we && wr != 0) begin
      mregs[wr]  = d;
      mcount     = mcount + 1;
      mlast_reg  = wr;
      mlast_data = d;
    end
    #1;
    RegWrite_W = 1'b0;
    #1;
    chk({tag, "_post_rd1"}, RD1, mregs[a1]);
    chk({tag, "_post_rd2"}, RD2, mregs[a2]);
    chk_state(tag);
  endtask

  task automatic sweep_zero(string tag);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      chk({tag, "_rd1"}, RD1, 32'd0);
      chk({tag, "_rd2"}, RD2, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; RegWrite_W = 1'b0; WriteReg_W = '0; Result_W = '0;
    A1 = '0; A2 = '0;
    model_clear();
    #2;
    chk_state("rst0");
    sweep_zero("rst0");

    // Write coincident with reset must be dropped.
    RegWrite_W = 1'b1; WriteReg_W = 5'd9; Result_W = 32'h1111_2222; A1 = 5'd9;
    @(posedge clk); #1;
    chk("rst_wr", RD1, 32'd0);
    chk_state("rst_wr");
    RegWrite_W = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    cycle("basic", 1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0);
    cycle("zero", 1, 5'd0, 32'h1234_5678, 5'd0, 5'd8);
    cycle("byp", 1, 5'd17, 32'hCAFE_F00D, 5'd17, 5'd17);
    cycle("w5", 1, 5'd5, 32'h0000_5555, 5'd5, 5'd8);
    cycle("dis", 0, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd17);

    for (int n = 0; n < 300; n++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 5'($urandom),
            $urandom, 5'($urandom), 5'($urandom));
    end

    // Random writes then reset, all state must clear.
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    chk_state("rst1");
    sweep_zero("rst1");
    @(negedge clk);
    reset = 1'b1;

    cycle("bb1", 1, 5'd1, 32'hA000_0001, 5'd1, 5'd2);
    cycle("bb2", 1, 5'd2, 32'hA000_0002, 5'd2, 5'd1);
    RegWrite_W = 1'b1; WriteReg_W = 5'd3; Result_W = 32'hA000_0003;
    #3;
    reset = 1'b0;
    model_clear();
    #1;
    chk_state("mid");
    sweep_zero("mid");
    RegWrite_W = 1'b1; WriteReg_W = 5'd4; Result_W = 32'hA000_0004;
    @(posedge clk); #1;
    chk_state("mid_hold");
    RegWrite_W = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycle("after", 1, 5'd3, 32'h0000_0042, 5'd3, 5'd4);
    sweep_zero_except3();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  task automatic sweep_zero_except3();
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      #1;
      chk("after_sweep", RD1, (i == 3) ? 32'h42 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL have port: RegWrite_W  input  1  write-back enable from WB stage.
REQ-004 SHALL have port: WriteReg_W  input  5  destination register index from WB stage.
REQ-005 SHALL have port: Result_W  input  32  write-back data selected by the WB result mux.
REQ-006 SHALL have port: A1  input  5  read address, port 1 (rs).
REQ-007 SHALL have port: A2  input  5  read address, port 2 (rt).
REQ-008 SHALL have port: RD1  output  32  read data, port 1.
REQ-009 SHALL have port: RD2  output  32  read data, port 2.
REQ-010 SHALL have port: WriteCount  output  32  number of committed nonzero-index writes since reset.
REQ-011 SHALL have port: LastWriteReg  output  5  index of most recent committed write.
REQ-012 SHALL have port: LastWriteData  output  32  data of most recent committed write.

Function
REQ-013 SHALL hold 32 registers of 32 bits, indices 0..31.
REQ-014 SHALL commit Result_W into register WriteReg_W on rising clk when RegWrite_W=1 and WriteReg_W!=0.
REQ-015 SHALL ignore writes to index 0; register 0 SHALL always read 0x00000000.
REQ-016 SHALL ignore writes when RegWrite_W=0, regardless of WriteReg_W/Result_W.
REQ-017 SHALL drive RD1/RD2 combinationally from A1/A2 (zero-cycle read latency).
REQ-018 SHALL allow A1==A2; both ports return the same value.
REQ-019 SHALL increment WriteCount by 1 on every committed write (REQ-014), wrapping 0xFFFFFFFF -> 0x00000000.
REQ-020 SHALL update LastWriteReg/LastWriteData on every committed write; unchanged otherwise.
REQ-021 SHALL treat a write to index 0 as not committed: no count increment, no LastWrite* update.

Reset
REQ-022 SHALL, while reset=0, asynchronously clear all 32 registers to 0x00000000.
REQ-023 SHALL, while reset=0, drive WriteCount=0, LastWriteReg=0, LastWriteData=0.
REQ-024 SHALL suppress any write coincident with reset=0; a write in the first edge after reset deassertion SHALL commit normally.
REQ-025 SHALL, if reset asserts mid-operation, discard all state with no partial write retained.

Configuration
REQ-026 SHALL use macro RF_WB_BYPASS_EN to control same-cycle write-to-read forwarding.
REQ-027 With RF_WB_BYPASS_EN defined, SHALL drive RDn=Result_W when RegWrite_W=1, WriteReg_W==An, An!=0, reset=1; otherwise stored value.
REQ-028 Without RF_WB_BYPASS_EN, SHALL drive RDn from stored registers only; same-cycle writes become visible after the clock edge.
REQ-029 In both builds, SHALL never bypass index 0 and SHALL never bypass while reset=0.

Verification
REQ-030 Reset: reset=0 after random writes -> all reads of 0..31 return 0, WriteCount=0, LastWriteReg=0.
REQ-031 Basic write: RegWrite_W=1, WriteReg_W=8, Result_W=0xDEADBEEF, one edge; A1=8 -> RD1=0xDEADBEEF, WriteCount=1, LastWriteReg=8.
REQ-032 Zero register: write 0x12345678 to index 0 -> RD1(A1=0)=0, WriteCount unchanged, LastWrite* unchanged.
REQ-033 Bypass: same cycle write 0xCAFEF00D to 17 with A1=A2=17 -> RD1=RD2=0xCAFEF00D before the edge with RF_WB_BYPASS_EN; old value (0 after reset) without it; both show 0xCAFEF00D after the edge.
REQ-034 Disabled write: RegWrite_W=0, WriteReg_W=5, Result_W=0xFFFFFFFF -> register 5 keeps prior value, WriteCount unchanged.
REQ-035 Reset mid-stream: assert reset=0 asynchronously between edges during back-to-back writes to 1..4 -> outputs clear immediately, no register nonzero, first write after release to 3 with 0x00000042 gives WriteCount=1.
